fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Sequences the instruction-fetch stage: owns the PC register and drives pc_sel for the PC mux.
//   Issues req/ack reads to instruction memory and presents fetched instructions to decode.
//   Handles hazard-unit stalls with a 1-entry buffer.
//   Handles EX-stage redirects (branch/jump target from the ALU), including discarding in-flight responses.
//   Sits between the PC mux and the IF/ID pipeline register.
// PARAMETERS
//   XLEN       32            datapath / address width
//   RESET_PC   32'h00000000  first fetch address after reset
//   TIMEOUT_W  4             width of the wait counter; timeout when count reaches 2**TIMEOUT_W-1
// PORTS
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous reset, active-low
//   stall_i        in   1     hazard unit: decode cannot accept a new instruction
//   redirect_i     in   1     EX: taken branch/jump this cycle
//   redirect_pc_i  in   XLEN  EX: target address (ALU result); bits [1:0] forced to 0
//   pc_sel_o       out  1     PC-mux select: 1 = redirect target, 0 = pc+4 (combinational = redirect_i)
//   imem_req_o     out  1     instruction-memory read request
//   imem_addr_o    out  XLEN  read address, stable while imem_req_o=1 and no ack
//   imem_ack_i     in   1     read data valid this cycle
//   imem_rdata_i   in   32    read data
//   if_valid_o     out  1     if_pc_o/if_instr_o hold a valid instruction
//   if_pc_o        out  XLEN  PC of the presented instruction
//   if_instr_o     out  32    presented instruction
//   timeout_o      out  1     sticky: memory failed to ack within 2**TIMEOUT_W-1 cycles
// BEHAVIOUR
//   Reset (rst=0, async, any time):
//   - pc=RESET_PC, state=BOOT, buffer empty, wait counter=0.
//   - All outputs 0 except imem_addr_o=RESET_PC.
//   - An outstanding request is abandoned.
//   States:
//   - BOOT: one cycle, req=0; -> REQ.
//   - REQ: req=1, addr=pc.
//     ack in same cycle -> capture; pc<=pc+4; stay REQ (back-to-back, 1 instr/cycle).
//     no ack -> WAIT.
//     stall_i=1 on entry -> req=0; remain in REQ (no issue).
//   - WAIT: req=1, addr held; counter++.
//     ack, stall_i=0 -> capture, pc<=pc+4, -> REQ.
//     ack, stall_i=1 -> rdata/pc into buffer, pc<=pc+4, -> HOLD.
//     Counter hits 2**TIMEOUT_W-1 -> timeout_o<=1 (cleared only by reset); stay WAIT.
//   - HOLD: req=0, if_* held.
//     stall_i=0 -> buffer moved to if_*, buffer cleared, -> REQ.
//   - DRAIN: req=1, addr held; ack -> discard data, -> REQ.
//   Capture: if_valid_o=1, if_pc_o=pc, if_instr_o=rdata on the edge after ack (1-cycle latency).
//   Stall:
//   - With stall_i=1, if_* never change except on redirect.
//   - With stall_i=0 and nothing captured this cycle, if_valid_o<=0.
//   Redirect (highest priority; redirect > stall > ack):
//   - pc<=redirect_pc_i; if_valid_o<=0; buffer cleared; counter cleared.
//   - From WAIT without same-cycle ack -> DRAIN.
//   - Otherwise -> REQ; a same-cycle ack is discarded.
//   - Redirect in DRAIN updates pc and stays DRAIN.
//   Arithmetic: pc+4 modulo 2**XLEN (32'hFFFFFFFC -> 32'h0); pc[1:0] always 0.
// TESTING
//   1. Reset release, ack every cycle, rdata=addr^32'hA5A5A5A5 -> req in cycle 2;
//      if_pc_o = 0,4,8,... one cycle after each ack; if_valid_o continuous.
//   2. ack delayed 3 cycles per request -> imem_addr_o stable during WAIT;
//      if_valid_o pulses once per fetch; no PC skipped.
//   3. stall_i=1 for 4 cycles with ack landing in WAIT -> if_* frozen, instruction buffered;
//      on release buffered PC presented next cycle, then fetch resumes at buffered PC+4.
//   4. redirect_i=1, redirect_pc_i=32'h00000102 while in WAIT -> pc_sel_o=1 that cycle;
//      late ack discarded; next req addr=32'h00000100; if_valid_o=0 until its ack.
//   5. redirect, stall and ack in the same cycle -> redirect wins; response discarded; buffer empty.
//   6. Start at pc=32'hFFFFFFFC -> next addr 32'h0.
//      No ack for 15 cycles -> timeout_o=1, stays set.
//      rst pulsed low mid-WAIT -> all outputs reset immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack imem reads, presents instructions to decode.
// Fetched data appears on if_* one cycle after ack; a stall freezes if_* and parks one response in a buffer.
module fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              TIMEOUT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            pc_sel_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            timeout_o
);

    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    state_t               state;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      buf_pc;
    logic [31:0]          buf_instr;
    logic [TIMEOUT_W-1:0] cnt;
    logic [XLEN-1:0]      redir_target;
    logic [XLEN-1:0]      pc_inc;

    assign pc_sel_o     = redirect_i;
    assign redir_target = redirect_pc_i & ~XLEN'(3);
    assign pc_inc       = pc + XLEN'(4);

    // REQ issues straight from pc; once a request is outstanding its address comes from addr_q,
    // because a redirect during DRAIN moves pc while the old request is still open.
    assign imem_req_o  = (state == REQ && !stall_i) || state == WAIT || state == DRAIN;
    assign imem_addr_o = (state == WAIT || state == DRAIN) ? addr_q : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            addr_q     <= RESET_PC;
            buf_pc     <= '0;
            buf_instr  <= '0;
            cnt        <= '0;
            timeout_o  <= 1'b0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_instr_o <= '0;
        end else begin
            // Counts consecutive unanswered request cycles; timeout is sticky until reset.
            if (redirect_i) begin
                cnt <= '0;
            end else if (imem_req_o && !imem_ack_i) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) timeout_o <= 1'b1;
            end else begin
                cnt <= '0;
            end

            if (redirect_i) begin
                pc         <= redir_target;
                if_valid_o <= 1'b0;
                // An open request that has not been answered must still be drained.
                if (state == DRAIN || (state == WAIT && !imem_ack_i))
                    state <= DRAIN;
                else
                    state <= REQ;
            end else begin
                case (state)
                    BOOT: begin
                        state <= REQ;
                        if (!stall_i) if_valid_o <= 1'b0;
                    end
                    REQ: begin
                        if (!stall_i) begin
                            if (imem_ack_i) begin
                                if_valid_o <= 1'b1;
                                if_pc_o    <= pc;
                                if_instr_o <= imem_rdata_i;
                                pc         <= pc_inc;
                            end else begin
                                if_valid_o <= 1'b0;
                                addr_q     <= pc;
                                state      <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (imem_ack_i) begin
                            pc <= pc_inc;
                            if (stall_i) begin
                                buf_pc    <= addr_q;
                                buf_instr <= imem_rdata_i;
                                state     <= HOLD;
                            end else begin
                                if_valid_o <= 1'b1;
                                if_pc_o    <= addr_q;
                                if_instr_o <= imem_rdata_i;
                                state      <= REQ;
                            end
                        end else if (!stall_i) begin
                            if_valid_o <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            if_valid_o <= 1'b1;
                            if_pc_o    <= buf_pc;
                            if_instr_o <= buf_instr;
                            state      <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (!stall_i) if_valid_o <= 1'b0;
                        if (imem_ack_i) state <= REQ;
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, wrap/timeout/reset sequence, random run against a model.
module tb_fetch_ctrl;

    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, ack;
    logic [31:0] redirect_pc, rdata;
    logic        pc_sel, req, vld, timeout;
    logic [31:0] addr, if_pc, if_instr;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .pc_sel_o(pc_sel), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata),
        .if_valid_o(vld), .if_pc_o(if_pc), .if_instr_o(if_instr),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t tab[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic s, input logic r, input logic [31:0] rp, input logic a,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rp; v.ack = a;
        v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep;
        tab.push_back(v);
    endtask

    task automatic apply(input logic s, input logic r, input logic [31:0] rp,
                         input logic a, input logic [31:0] rd);
        stall = s; redirect = r; redirect_pc = rp; ack = a; rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference model state: event-level view of the fetch stage.
    logic        m_boot, m_out, m_drop, m_vld, m_to;
    logic [31:0] m_pc, m_oaddr, m_ipc, m_instr;
    int          m_cnt;
    ent_t        m_buf[$];

    initial begin
        logic        s, r, a, e_req, acked;
        logic [31:0] rp, rd, e_addr;
        ent_t        e;

        rst = 1'b0;
        apply(0, 0, 0, 0, 0);
        #10;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_vld", vld, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        //   stall redir rpc           ack  req addr          vld pc
        row(0, 0, 0,            0,   0, 32'h0,        0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h0,        1, 32'h0);
        row(0, 0, 0,            1,   1, 32'h4,        1, 32'h4);
        row(0, 0, 0,            1,   1, 32'h8,        1, 32'h8);
        row(0, 0, 0,            0,   1, 32'hC,        0, 32'h0);
        row(0, 0, 0,            0,   1, 32'hC,        0, 32'h0);
        row(0, 0, 0,            0,   1, 32'hC,        0, 32'h0);
        row(0, 0, 0,            1,   1, 32'hC,        1, 32'hC);
        row(0, 0, 0,            0,   1, 32'h10,       0, 32'h0);
        row(0, 0, 0,            0,   1, 32'h10,       0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h10,       1, 32'h10);
        row(0, 0, 0,            0,   1, 32'h14,       0, 32'h0);
        row(1, 0, 0,            0,   1, 32'h14,       0, 32'h0);
        row(1, 0, 0,            1,   1, 32'h14,       0, 32'h0);
        row(1, 0, 0,            0,   0, 32'h0,        0, 32'h0);
        row(1, 0, 0,            0,   0, 32'h0,        0, 32'h0);
        row(0, 0, 0,            0,   0, 32'h0,        1, 32'h14);
        row(0, 0, 0,            1,   1, 32'h18,       1, 32'h18);
        row(1, 0, 0,            0,   0, 32'h0,        1, 32'h18);
        row(0, 0, 0,            1,   1, 32'h1C,       1, 32'h1C);
        row(0, 0, 0,            0,   1, 32'h20,       0, 32'h0);
        row(0, 1, 32'h102,      0,   1, 32'h20,       0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h20,       0, 32'h0);
        row(0, 0, 0,            0,   1, 32'h100,      0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h100,      1, 32'h100);
        row(0, 0, 0,            0,   1, 32'h104,      0, 32'h0);
        row(1, 1, 32'h200,      1,   1, 32'h104,      0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h200,      1, 32'h200);
        row(0, 1, 32'h300,      1,   1, 32'h204,      0, 32'h0);
        row(0, 0, 0,            1,   1, 32'h300,      1, 32'h300);

        foreach (tab[i]) begin
            apply(tab[i].stall, tab[i].redir, tab[i].rpc, tab[i].ack, tab[i].e_addr ^ K);
            chk($sformatf("t%0d_req", i), req, tab[i].e_req);
            chk($sformatf("t%0d_sel", i), pc_sel, tab[i].redir);
            if (tab[i].e_req) chk($sformatf("t%0d_addr", i), addr, tab[i].e_addr);
            tick();
            chk($sformatf("t%0d_vld", i), vld, tab[i].e_vld);
            if (tab[i].e_vld) begin
                chk($sformatf("t%0d_pc", i), if_pc, tab[i].e_pc);
                chk($sformatf("t%0d_instr", i), if_instr, tab[i].e_pc ^ K);
            end
            chk($sformatf("t%0d_timeout", i), timeout, 0);
        end

        // PC wrap, timeout after 15 unanswered cycles, asynchronous reset mid-WAIT.
        reset_dut();
        apply(0, 1, 32'hFFFFFFFD, 0, 0);
        chk("boot_sel", pc_sel, 1);
        chk("boot_req", req, 0);
        tick();
        apply(0, 0, 0, 1, 32'h1234);
        chk("wrap_req", req, 1);
        chk("wrap_addr_top", addr, 32'hFFFFFFFC);
        tick();
        chk("wrap_vld", vld, 1);
        chk("wrap_pc", if_pc, 32'hFFFFFFFC);
        chk("wrap_instr", if_instr, 32'h1234);
        for (int i = 1; i <= 15; i++) begin
            apply(0, 0, 0, 0, 0);
            chk($sformatf("wrap_addr_%0d", i), addr, 32'h0);
            tick();
            chk($sformatf("timeout_%0d", i), timeout, (i == 15) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0);
            tick();
            chk("timeout_sticky", timeout, 1);
        end
        apply(0, 0, 0, 1, 32'h5555);
        tick();
        chk("late_vld", vld, 1);
        chk("late_pc", if_pc, 32'h0);
        chk("timeout_after_ack", timeout, 1);
        apply(0, 0, 0, 0, 0);
        tick();
        chk("midwait_req", req, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_addr", addr, 0);
        chk("arst_vld", vld, 0);
        chk("arst_pc", if_pc, 0);
        chk("arst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random run against the model.
        reset_dut();
        m_boot = 1; m_out = 0; m_drop = 0; m_vld = 0; m_to = 0;
        m_pc = 0; m_oaddr = 0; m_ipc = 0; m_instr = 0; m_cnt = 0;
        m_buf.delete();
        for (int c = 0; c < 3000; c++) begin
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 8);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
            e_req  = !m_boot && m_buf.size() == 0 && (m_out || !s);
            e_addr = m_out ? m_oaddr : m_pc;
            a  = e_req && ($urandom_range(0, 99) < 45);
            rd = $urandom;
            apply(s, r, rp, a, rd);
            chk("rnd_req", req, e_req);
            chk("rnd_sel", pc_sel, r);
            if (e_req) chk("rnd_addr", addr, e_addr);

            acked = e_req && a;
            if (r) m_cnt = 0;
            else if (e_req && !a) begin
                if (m_cnt < 15) m_cnt++;
                if (m_cnt == 15) m_to = 1;
            end else m_cnt = 0;

            if (r) begin
                m_pc   = rp & 32'hFFFFFFFC;
                m_vld  = 0;
                m_boot = 0;
                m_buf.delete();
                if (m_out && (m_drop || !acked)) m_drop = 1;
                else begin m_out = 0; m_drop = 0; end
            end else if (m_boot) begin
                m_boot = 0;
                if (!s) m_vld = 0;
            end else if (m_buf.size() != 0) begin
                if (!s) begin
                    e = m_buf.pop_front();
                    m_vld = 1; m_ipc = e.pc; m_instr = e.instr;
                end
            end else if (acked) begin
                m_out = 0;
                if (m_drop) begin
                    m_drop = 0;
                    if (!s) m_vld = 0;
                end else begin
                    m_pc = m_pc + 32'd4;
                    if (s) begin
                        e.pc = e_addr; e.instr = rd;
                        m_buf.push_back(e);
                    end else begin
                        m_vld = 1; m_ipc = e_addr; m_instr = rd;
                    end
                end
            end else begin
                if (e_req) begin m_out = 1; m_oaddr = e_addr; end
                if (!s) m_vld = 0;
            end

            tick();
            chk("rnd_vld", vld, m_vld);
            if (m_vld) begin
                chk("rnd_pc", if_pc, m_ipc);
                chk("rnd_instr", if_instr, m_instr);
            end
            chk("rnd_timeout", timeout, m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
